avmm_to_axi_lite_bridge: RTL and testbench
==========================================

// Module: avmm_to_axi_lite_bridge
// PURPOSE
//  Converts single-beat Avalon-MM master requests into AXI4-Lite master transactions.
//  Sits between a register-access master (CSR/testbench driver) and an AXI4-Lite slave.
//  Only one transaction is outstanding at a time; there is no bursting or pipelining.
// PARAMETERS
//  ADDR_WIDTH  32  width of avmm_address_i / axi_lite_awaddr_o / axi_lite_araddr_o
//  DATA_WIDTH  32  data width; strobe width is DATA_WIDTH/8
// PORTS
//  aclk                   in   1     clock; all logic is rising-edge synchronous
//  aresetn                in   1     reset; asynchronous assertion, active-low
//  avmm_address_i         in   AW    request address
//  avmm_writedata_i       in   DW    write data
//  avmm_byteenable_i      in   DW/8  write byte enables
//  avmm_read_i            in   1     read request; held until accepted
//  avmm_write_i           in   1     write request; held until accepted
//  avmm_readdata_o        out  DW    read data; valid with readdata_valid and held afterwards
//  avmm_waitrequest_o     out  1     low for exactly one cycle = request accepted
//  avmm_readdata_valid_o  out  1     one-cycle pulse when read data is returned
//  axi_lite_aw{valid_o,ready_i,prot_o[2:0],addr_o[AW]}  write address channel
//  axi_lite_w{data_o[DW],strb_o[DW/8],valid_o,ready_i}   write data channel
//  axi_lite_b{valid_i,ready_o,resp_i[1:0]}               write response channel
//  axi_lite_ar{valid_o,ready_i,prot_o[2:0],addr_o[AW]}  read address channel
//  axi_lite_r{data_i[DW],resp_i[1:0],valid_i,ready_o}    read data channel
// BEHAVIOUR
//  Reset (aresetn=0, async): state IDLE; waitrequest=1; all *valid_o, bready_o, rready_o,
//   and readdata_valid_o are 0; readdata_o=0; the address, data and strobe registers are 0.
//   Assertion mid-transaction aborts the transaction immediately.
//  awprot_o and arprot_o are held at 3'b000. AXI outputs are registered.
//  FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, TURN.
//  IDLE: on write_i, capture the address, writedata and byteenable, then go to WR_ADDR_DATA with awvalid=wvalid=1.
//   Otherwise, on read_i, capture the address and go to RD_ADDR with arvalid=1. Write wins if both are high.
//  WR_ADDR_DATA: clear awvalid on awready and wvalid on wready, independently in any order or together.
//   Once both handshakes are done, go to WR_RESP with bready=1.
//  WR_RESP: on bvalid, clear bready, drive waitrequest=0 for one cycle, then go to TURN.
//   bresp is ignored; the transaction completes regardless.
//  RD_ADDR: on arready, clear arvalid and drive waitrequest=0 for one cycle (command accepted).
//   Then go to RD_DATA with rready=1.
//  RD_DATA: on rvalid, register rdata into readdata_o and pulse readdata_valid_o for one cycle.
//   Clear rready and go to TURN. readdata_valid is never in the same cycle as the read's waitrequest=0 pulse.
//   rresp is ignored.
//  TURN: one cycle in which all requests are ignored and waitrequest=1, then go to IDLE.
//   This absorbs a master that deasserts read_i/write_i one cycle after it sees waitrequest low.
//  waitrequest is 1 in every cycle except the single acceptance cycle.
//  AXI valids are held until their ready arrives (no retraction). awaddr/wdata/wstrb/araddr stay stable while valid.
//  readdata_o holds its last value until the next R beat is captured.
//  Slave ready asserted before valid (ready-first) must work; zero-wait slaves cost no extra cycles beyond the FSM.
// TESTING
//  Write 0x10=0xDEADBEEF, strobe F, slave readies high: one AW and one W beat with those values, then bready.
//   Then one waitrequest=0 pulse and exactly one AXI write total.
//  Write with wready 3 cycles before awready: W completes first, AW later.
//   B is awaited only after both; wvalid stays low after its handshake.
//  Read 0x20, slave returns 0x12345678 after 4-cycle rvalid delay: waitrequest=0 on AR accept.
//   Later, readdata_valid pulses with readdata_o=0x12345678, held after the pulse.
//  Back-to-back write, read, and read_chk with the master holding requests one cycle past acceptance.
//   Exactly three AXI transactions, no duplicates.
//  aresetn dropped during WR_RESP: all valids/readies go to 0 asynchronously and waitrequest goes to 1.
//   After reset release, a new write completes normally.
//  bresp=2'b10 and rresp=2'b11: transactions still complete; rdata is still delivered.

Source files
------------

// File: rtl/avmm_to_axi_lite_bridge_if.sv
// Bus bundles for the Avalon-MM to AXI4-Lite bridge: the Avalon-MM request side
// and the AXI4-Lite master side. Signal names match the original flat ports.
interface avmm_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   avmm_address_i;
    logic [DATA_WIDTH-1:0]   avmm_writedata_i;
    logic [DATA_WIDTH/8-1:0] avmm_byteenable_i;
    logic                    avmm_read_i;
    logic                    avmm_write_i;
    logic [DATA_WIDTH-1:0]   avmm_readdata_o;
    logic                    avmm_waitrequest_o;
    logic                    avmm_readdata_valid_o;

    modport master (
        output avmm_address_i, avmm_writedata_i, avmm_byteenable_i,
               avmm_read_i, avmm_write_i,
        input  avmm_readdata_o, avmm_waitrequest_o, avmm_readdata_valid_o
    );

    modport slave (
        input  avmm_address_i, avmm_writedata_i, avmm_byteenable_i,
               avmm_read_i, avmm_write_i,
        output avmm_readdata_o, avmm_waitrequest_o, avmm_readdata_valid_o
    );
endinterface

interface axi_lite_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    axi_lite_awvalid_o;
    logic                    axi_lite_awready_i;
    logic [2:0]              axi_lite_awprot_o;
    logic [ADDR_WIDTH-1:0]   axi_lite_awaddr_o;
    logic [DATA_WIDTH-1:0]   axi_lite_wdata_o;
    logic [DATA_WIDTH/8-1:0] axi_lite_wstrb_o;
    logic                    axi_lite_wvalid_o;
    logic                    axi_lite_wready_i;
    logic                    axi_lite_bvalid_i;
    logic                    axi_lite_bready_o;
    logic [1:0]              axi_lite_bresp_i;
    logic                    axi_lite_arvalid_o;
    logic                    axi_lite_arready_i;
    logic [2:0]              axi_lite_arprot_o;
    logic [ADDR_WIDTH-1:0]   axi_lite_araddr_o;
    logic [DATA_WIDTH-1:0]   axi_lite_rdata_i;
    logic [1:0]              axi_lite_rresp_i;
    logic                    axi_lite_rvalid_i;
    logic                    axi_lite_rready_o;

    modport master (
        output axi_lite_awvalid_o, axi_lite_awprot_o, axi_lite_awaddr_o,
               axi_lite_wdata_o, axi_lite_wstrb_o, axi_lite_wvalid_o,
               axi_lite_bready_o, axi_lite_arvalid_o, axi_lite_arprot_o,
               axi_lite_araddr_o, axi_lite_rready_o,
        input  axi_lite_awready_i, axi_lite_wready_i, axi_lite_bvalid_i,
               axi_lite_bresp_i, axi_lite_arready_i, axi_lite_rdata_i,
               axi_lite_rresp_i, axi_lite_rvalid_i
    );

    modport slave (
        input  axi_lite_awvalid_o, axi_lite_awprot_o, axi_lite_awaddr_o,
               axi_lite_wdata_o, axi_lite_wstrb_o, axi_lite_wvalid_o,
               axi_lite_bready_o, axi_lite_arvalid_o, axi_lite_arprot_o,
               axi_lite_araddr_o, axi_lite_rready_o,
        output axi_lite_awready_i, axi_lite_wready_i, axi_lite_bvalid_i,
               axi_lite_bresp_i, axi_lite_arready_i, axi_lite_rdata_i,
               axi_lite_rresp_i, axi_lite_rvalid_i
    );
endinterface

// File: rtl/avmm_to_axi_lite_bridge.sv
// Single-outstanding Avalon-MM to AXI4-Lite bridge. AXI outputs are registered;
// waitrequest drops combinationally in the one cycle the request is accepted.
module avmm_to_axi_lite_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic       aclk,
    input  logic       aresetn,
    avmm_if.slave      avmm,
    axi_lite_if.master axi
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        TURN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rdvalid_q, rdvalid_d;
    logic                    waitrequest;
    logic                    unused_resp;

    assign unused_resp = ^{axi.axi_lite_bresp_i, axi.axi_lite_rresp_i};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rdvalid_q <= rdvalid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rdvalid_d   = 1'b0;
        waitrequest = 1'b1;

        case (state_q)
            IDLE: begin
                if (avmm.avmm_write_i) begin
                    addr_d    = avmm.avmm_address_i;
                    wdata_d   = avmm.avmm_writedata_i;
                    wstrb_d   = avmm.avmm_byteenable_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR_ADDR_DATA;
                end else if (avmm.avmm_read_i) begin
                    addr_d    = avmm.avmm_address_i;
                    arvalid_d = 1'b1;
                    state_d   = RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; B is only opened once both are gone.
                if (axi.axi_lite_awready_i) awvalid_d = 1'b0;
                if (axi.axi_lite_wready_i)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.axi_lite_bvalid_i) begin
                    bready_d    = 1'b0;
                    waitrequest = 1'b0;
                    state_d     = TURN;
                end
            end
            RD_ADDR: begin
                if (axi.axi_lite_arready_i) begin
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b1;
                    waitrequest = 1'b0;
                    state_d     = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.axi_lite_rvalid_i) begin
                    rdata_d   = axi.axi_lite_rdata_i;
                    rdvalid_d = 1'b1;
                    rready_d  = 1'b0;
                    state_d   = TURN;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign avmm.avmm_readdata_o       = rdata_q;
    assign avmm.avmm_readdata_valid_o = rdvalid_q;
    assign avmm.avmm_waitrequest_o    = waitrequest;

    assign axi.axi_lite_awvalid_o = awvalid_q;
    assign axi.axi_lite_awprot_o  = '0;
    assign axi.axi_lite_awaddr_o  = addr_q;
    assign axi.axi_lite_wdata_o   = wdata_q;
    assign axi.axi_lite_wstrb_o   = wstrb_q;
    assign axi.axi_lite_wvalid_o  = wvalid_q;
    assign axi.axi_lite_bready_o  = bready_q;
    assign axi.axi_lite_arvalid_o = arvalid_q;
    assign axi.axi_lite_arprot_o  = '0;
    assign axi.axi_lite_araddr_o  = addr_q;
    assign axi.axi_lite_rready_o  = rready_q;
endmodule

// File: tb/tb_avmm_to_axi_lite_bridge.sv
// Bench for avmm_to_axi_lite_bridge: vector table driven through an Avalon master,
// delay-configurable AXI4-Lite slave model, scoreboard queues for writes and reads.
module tb_avmm_to_axi_lite_bridge;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    avmm_if     #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) avmm ();
    axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    avmm_to_axi_lite_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .avmm    (avmm),
        .axi     (axi)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Slave knobs and scoreboards
    int unsigned      aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]       resp_k = 2'b00;
    logic [DW-1:0]    rdata_k = '0;
    logic [71:0]      wr_q[$];
    logic [AW-1:0]    ar_q[$];
    logic [DW-1:0]    rd_q[$];

    int unsigned      aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int unsigned      n_aw, n_w, n_b, n_ar, n_r;
    logic             aw_got, w_got, b_pend, r_pend;
    logic [AW-1:0]    aw_addr_s;
    logic [DW-1:0]    w_data_s;
    logic [SW-1:0]    w_strb_s;
    logic             aw_stall, w_stall, ar_stall;
    logic [AW-1:0]    aw_addr_p, ar_addr_p;
    logic [DW-1:0]    w_data_p;
    logic [SW-1:0]    w_strb_p;
    logic             hs_aw, hs_w, stable_ok;
    logic [71:0]      wr_act;

    assign axi.axi_lite_awready_i = (aw_wait >= aw_dly);
    assign axi.axi_lite_wready_i  = (w_wait >= w_dly);
    assign axi.axi_lite_arready_i = (ar_wait >= ar_dly);
    assign axi.axi_lite_bvalid_i  = b_pend && (b_wait >= b_dly);
    assign axi.axi_lite_rvalid_i  = r_pend && (r_wait >= r_dly);
    assign axi.axi_lite_bresp_i   = resp_k;
    assign axi.axi_lite_rresp_i   = resp_k;
    assign axi.axi_lite_rdata_i   = rdata_k;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_stall <= 1'b0; w_stall <= 1'b0; ar_stall <= 1'b0;
        end else begin
            hs_aw = axi.axi_lite_awvalid_o && axi.axi_lite_awready_i;
            hs_w  = axi.axi_lite_wvalid_o && axi.axi_lite_wready_i;
            // Valids must not retract and payload must not move while stalled
            if (aw_stall || w_stall || ar_stall) begin
                stable_ok = (!aw_stall || (axi.axi_lite_awvalid_o && axi.axi_lite_awaddr_o == aw_addr_p))
                         && (!w_stall || (axi.axi_lite_wvalid_o && axi.axi_lite_wdata_o == w_data_p
                                          && axi.axi_lite_wstrb_o == w_strb_p))
                         && (!ar_stall || (axi.axi_lite_arvalid_o && axi.axi_lite_araddr_o == ar_addr_p));
                check("stable_while_valid", stable_ok, 1);
            end
            aw_stall  <= axi.axi_lite_awvalid_o && !axi.axi_lite_awready_i;
            w_stall   <= axi.axi_lite_wvalid_o && !axi.axi_lite_wready_i;
            ar_stall  <= axi.axi_lite_arvalid_o && !axi.axi_lite_arready_i;
            aw_addr_p <= axi.axi_lite_awaddr_o;
            w_data_p  <= axi.axi_lite_wdata_o;
            w_strb_p  <= axi.axi_lite_wstrb_o;
            ar_addr_p <= axi.axi_lite_araddr_o;

            if (hs_aw) begin
                aw_wait <= 0; aw_got <= 1'b1; aw_addr_s <= axi.axi_lite_awaddr_o; n_aw <= n_aw + 1;
            end else if (axi.axi_lite_awvalid_o) aw_wait <= aw_wait + 1;
            if (hs_w) begin
                w_wait <= 0; w_got <= 1'b1; w_data_s <= axi.axi_lite_wdata_o;
                w_strb_s <= axi.axi_lite_wstrb_o; n_w <= n_w + 1;
            end else if (axi.axi_lite_wvalid_o) w_wait <= w_wait + 1;

            if (!b_pend && (aw_got || hs_aw) && (w_got || hs_w) && (hs_aw || hs_w)) begin
                wr_act = {hs_aw ? axi.axi_lite_awaddr_o : aw_addr_s,
                          hs_w ? axi.axi_lite_wdata_o : w_data_s,
                          hs_w ? axi.axi_lite_wstrb_o : w_strb_s};
                if (wr_q.size() == 0) check("unexpected_write", wr_act, '0);
                else check("write_beat", wr_act, wr_q.pop_front());
                b_pend <= 1'b1;
                b_wait <= 0;
            end
            if (axi.axi_lite_bready_o) check("bready_after_aw_w", aw_got && w_got, 1);
            if (b_pend && axi.axi_lite_bvalid_i && axi.axi_lite_bready_o) begin
                b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; n_b <= n_b + 1;
            end else if (b_pend) b_wait <= b_wait + 1;

            if (axi.axi_lite_arvalid_o && axi.axi_lite_arready_i) begin
                if (ar_q.size() == 0) check("unexpected_read", axi.axi_lite_araddr_o, '1);
                else check("araddr", axi.axi_lite_araddr_o, ar_q.pop_front());
                ar_wait <= 0; r_pend <= 1'b1; r_wait <= 0; n_ar <= n_ar + 1;
            end else if (axi.axi_lite_arvalid_o) ar_wait <= ar_wait + 1;
            if (r_pend && axi.axi_lite_rvalid_i && axi.axi_lite_rready_o) begin
                r_pend <= 1'b0; n_r <= n_r + 1;
            end else if (r_pend) r_wait <= r_wait + 1;
        end
    end

    always @(negedge aclk) begin
        if (aresetn && avmm.avmm_readdata_valid_o) begin
            check("rdvalid_not_with_accept", avmm.avmm_waitrequest_o, 1);
            if (rd_q.size() == 0) check("unexpected_readdata", avmm.avmm_readdata_o, '1);
            else check("readdata", avmm.avmm_readdata_o, rd_q.pop_front());
        end
    end

    typedef struct {
        bit            wr;
        bit            both;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        int unsigned   aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]    resp;
        bit            hold;
        logic [DW-1:0] exp_rdata;
        int unsigned   exp_wr_n;
        int unsigned   exp_rd_n;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        int unsigned b_aw, b_w, b_b, b_ar, b_r;
        bit got;
        aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
        resp_k = v.resp; rdata_k = v.data;
        b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar; b_r = n_r;
        @(negedge aclk);
        avmm.avmm_address_i    = v.addr;
        avmm.avmm_writedata_i  = v.data;
        avmm.avmm_byteenable_i = v.strb;
        avmm.avmm_write_i      = v.wr;
        avmm.avmm_read_i       = !v.wr || v.both;
        if (v.wr) wr_q.push_back({v.addr, v.data, v.strb});
        else begin
            ar_q.push_back(v.addr);
            rd_q.push_back(v.exp_rdata);
        end
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (!avmm.avmm_waitrequest_o) begin got = 1; break; end
        end
        check("accept_seen", got, 1);
        @(negedge aclk);
        check("waitrequest_one_cycle", avmm.avmm_waitrequest_o, 1);
        if (v.hold) @(negedge aclk);
        avmm.avmm_write_i = 1'b0;
        avmm.avmm_read_i  = 1'b0;
        if (!v.wr) begin
            got = 0;
            for (int i = 0; i < 100; i++) begin
                if (avmm.avmm_readdata_valid_o) begin got = 1; break; end
                @(negedge aclk);
            end
            check("readdata_valid_seen", got, 1);
            @(negedge aclk);
            check("readdata_valid_pulse", avmm.avmm_readdata_valid_o, 0);
            check("readdata_held", avmm.avmm_readdata_o, v.exp_rdata);
        end
        repeat (3) @(negedge aclk);
        check("aw_count", n_aw - b_aw, v.exp_wr_n);
        check("w_count",  n_w - b_w,   v.exp_wr_n);
        check("b_count",  n_b - b_b,   v.exp_wr_n);
        check("ar_count", n_ar - b_ar, v.exp_rd_n);
        check("r_count",  n_r - b_r,   v.exp_rd_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit got;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        vecs[0] = '{wr:1, both:0, addr:32'h10, data:32'hDEADBEEF, strb:4'hF, aw_d:0, w_d:0, b_d:0,
                    ar_d:0, r_d:0, resp:2'b00, hold:0, exp_rdata:'0, exp_wr_n:1, exp_rd_n:0};
        vecs[1] = '{wr:1, both:0, addr:32'h14, data:32'hCAFEF00D, strb:4'h5, aw_d:3, w_d:0, b_d:2,
                    ar_d:0, r_d:0, resp:2'b00, hold:0, exp_rdata:'0, exp_wr_n:1, exp_rd_n:0};
        vecs[2] = '{wr:1, both:0, addr:32'h18, data:32'h01020304, strb:4'hA, aw_d:0, w_d:2, b_d:0,
                    ar_d:0, r_d:0, resp:2'b10, hold:1, exp_rdata:'0, exp_wr_n:1, exp_rd_n:0};
        vecs[3] = '{wr:0, both:0, addr:32'h20, data:32'h12345678, strb:4'h0, aw_d:0, w_d:0, b_d:0,
                    ar_d:0, r_d:4, resp:2'b00, hold:0, exp_rdata:32'h12345678, exp_wr_n:0, exp_rd_n:1};
        vecs[4] = '{wr:0, both:0, addr:32'h24, data:32'hA5A55A5A, strb:4'h0, aw_d:0, w_d:0, b_d:0,
                    ar_d:2, r_d:0, resp:2'b11, hold:1, exp_rdata:32'hA5A55A5A, exp_wr_n:0, exp_rd_n:1};
        vecs[5] = '{wr:1, both:0, addr:32'h30, data:32'h0BADCAFE, strb:4'hF, aw_d:0, w_d:0, b_d:0,
                    ar_d:0, r_d:0, resp:2'b00, hold:1, exp_rdata:'0, exp_wr_n:1, exp_rd_n:0};
        vecs[6] = '{wr:0, both:0, addr:32'h34, data:32'h11112222, strb:4'h0, aw_d:0, w_d:0, b_d:0,
                    ar_d:0, r_d:0, resp:2'b00, hold:1, exp_rdata:32'h11112222, exp_wr_n:0, exp_rd_n:1};
        vecs[7] = '{wr:0, both:0, addr:32'h38, data:32'h33334444, strb:4'h0, aw_d:0, w_d:0, b_d:0,
                    ar_d:1, r_d:1, resp:2'b00, hold:1, exp_rdata:32'h33334444, exp_wr_n:0, exp_rd_n:1};
        vecs[8] = '{wr:1, both:1, addr:32'h3C, data:32'h55667788, strb:4'h3, aw_d:1, w_d:1, b_d:1,
                    ar_d:0, r_d:0, resp:2'b00, hold:0, exp_rdata:'0, exp_wr_n:1, exp_rd_n:0};

        avmm.avmm_address_i    = '0;
        avmm.avmm_writedata_i  = '0;
        avmm.avmm_byteenable_i = '0;
        avmm.avmm_read_i       = 1'b0;
        avmm.avmm_write_i      = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_waitrequest", avmm.avmm_waitrequest_o, 1);
        check("rst_valids_readies", {axi.axi_lite_awvalid_o, axi.axi_lite_wvalid_o, axi.axi_lite_bready_o,
                                     axi.axi_lite_arvalid_o, axi.axi_lite_rready_o,
                                     avmm.avmm_readdata_valid_o}, 6'b0);
        check("rst_readdata", avmm.avmm_readdata_o, 0);
        check("rst_addr_data_strb", {axi.axi_lite_awaddr_o, axi.axi_lite_wdata_o, axi.axi_lite_wstrb_o}, 0);
        check("prot_zero", {axi.axi_lite_awprot_o, axi.axi_lite_arprot_o}, 0);
        aresetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort a write while it waits for B, then confirm the bridge recovers
        aw_dly = 0; w_dly = 0; b_dly = 8;
        @(negedge aclk);
        avmm.avmm_address_i    = 32'h40;
        avmm.avmm_writedata_i  = 32'hFEEDFACE;
        avmm.avmm_byteenable_i = 4'hF;
        avmm.avmm_write_i      = 1'b1;
        wr_q.push_back({32'h40, 32'hFEEDFACE, 4'hF});
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (axi.axi_lite_bready_o) begin got = 1; break; end
        end
        check("reached_wr_resp", got, 1);
        #2 aresetn = 1'b0;
        #1;
        check("abort_valids_readies", {axi.axi_lite_awvalid_o, axi.axi_lite_wvalid_o, axi.axi_lite_bready_o,
                                       axi.axi_lite_arvalid_o, axi.axi_lite_rready_o}, 5'b0);
        check("abort_waitrequest", avmm.avmm_waitrequest_o, 1);
        avmm.avmm_write_i = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        run_vec(vecs[0]);

        check("write_queue_drained", wr_q.size(), 0);
        check("read_queue_drained", rd_q.size() + ar_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
